// File: rtl/hex_display_scanner.sv
// hex_display_scanner
//
// Time-multiplexed driver for a 4-digit, common-anode 7-segment display.
// A 16-bit value (one nibble per digit, digit 0 = least significant) is
// latched into a shadow register once per frame, so a frame never mixes
// digits from two different values. Each digit gets a dwell of CLK_DIV
// cycles. The first BLANK_CYCLES cycles of a dwell keep every digit dark to
// prevent ghosting, and the rest of the dwell drives the decoded segments.
// When BLANK_LEADING is set, leading zero digits (never digit 0) are left dark.
//
// Parameters:
//   CLK_DIV       - cycles per digit dwell (must exceed BLANK_CYCLES)
//   BLANK_CYCLES  - dark cycles at the start of every dwell (0 = none)
//   BLANK_LEADING - 1 = suppress leading zero digits
//
// Ports:
//   clk        - system clock
//   reset      - synchronous, active-high reset
//   value_in   - value to display, nibble i -> digit i
//   enable     - 1 = scan the display, 0 = all digits off
//   an_n       - active-low digit enables, bit i = digit i
//   seg_n      - active-low segments {g,f,e,d,c,b,a}
//   frame_done - one-cycle pulse during the last cycle of digit 3's dwell
module hex_display_scanner #(
    parameter int CLK_DIV       = 50000,
    parameter int BLANK_CYCLES  = 500,
    parameter int BLANK_LEADING = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value_in,
    input  logic        enable,
    output logic [3:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } state_t;

    // The counter needs at least one bit even when CLK_DIV is 1.
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    // With no blanking gap, every dwell starts directly in DRIVE.
    localparam state_t DWELL_START = (BLANK_CYCLES > 0) ? BLANK : DRIVE;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0]    idx, idx_nx;
    logic [15:0]   shadow, shadow_nx;
    logic [3:0]    an_nx;
    logic [6:0]    seg_nx;
    logic          done_nx;

    function automatic logic [6:0] decode(input logic [3:0] nibble);
        logic [6:0] s;
        case (nibble)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // A digit above digit 0 is a leading zero when it and every more
    // significant nibble are zero.
    function automatic logic leading_zero(input logic [15:0] s, input logic [1:0] i);
        logic z;
        case (i)
            2'd1:    z = (s[15:4] == 12'h000);
            2'd2:    z = (s[15:8] == 8'h00);
            2'd3:    z = (s[15:12] == 4'h0);
            default: z = 1'b0;
        endcase
        return z;
    endfunction

    // Next-state logic. Dropping enable wins over everything else, including
    // the frame-boundary capture. The shadow register only reloads when the
    // scan starts and when digit 3's dwell wraps back to digit 0.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        idx_nx    = idx;
        shadow_nx = shadow;
        if (!enable) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            idx_nx   = 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx  = DWELL_START;
                    cnt_nx    = '0;
                    idx_nx    = 2'd0;
                    shadow_nx = value_in;
                end
                BLANK: begin
                    cnt_nx = cnt + 1'b1;
                    if (cnt == BLANK_LAST) begin
                        state_nx = DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt == CNT_LAST) begin
                        cnt_nx   = '0;
                        idx_nx   = idx + 2'd1;
                        state_nx = DWELL_START;
                        if (idx == 2'd3) begin
                            shadow_nx = value_in;
                        end
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    idx_nx   = 2'd0;
                end
            endcase
        end
    end

    // Output logic is driven from the next-state values, so the registered
    // pins line up with the state, idx and cnt of the same cycle.
    // frame_done is high in the terminal cycle of digit 3's dwell.
    always_comb begin
        an_nx   = 4'hF;
        seg_nx  = 7'h7F;
        done_nx = (state_nx == DRIVE) && (idx_nx == 2'd3) && (cnt_nx == CNT_LAST);
        if (state_nx == DRIVE) begin
            an_nx = ~(4'b0001 << idx_nx);
            if ((BLANK_LEADING != 0) && leading_zero(shadow_nx, idx_nx)) begin
                seg_nx = 7'h7F;
            end else begin
                seg_nx = decode(shadow_nx[4*idx_nx +: 4]);
            end
        end
    end

    // State and output registers; reset wins over any activity.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= 2'd0;
            shadow     <= 16'h0000;
            an_n       <= 4'hF;
            seg_n      <= 7'h7F;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            idx        <= idx_nx;
            shadow     <= shadow_nx;
            an_n       <= an_nx;
            seg_n      <= seg_nx;
            frame_done <= done_nx;
        end
    end

endmodule
